// File: rtl/shift_arbiter_if.sv
// Request/grant/result bundle between the two shift requesters and shift_arbiter.
// master: requester side (req/in/val/mode out); slave: arbiter side (gnt/done/result out).
interface shift_arbiter_if;
  logic        req0;
  logic        req1;
  logic [15:0] in0;
  logic [15:0] in1;
  logic [3:0]  val0;
  logic [3:0]  val1;
  logic [1:0]  mode0;
  logic [1:0]  mode1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [15:0] shift_out;
  logic        zero;
  logic        busy;
  logic        illegal;

  modport master (
    output req0, req1, in0, in1,
    output val0, val1, mode0, mode1,
    input  gnt0, gnt1, done0, done1,
    input  shift_out, zero, busy, illegal
  );

  modport slave (
    input  req0, req1, in0, in1,
    input  val0, val1, mode0, mode1,
    output gnt0, gnt1, done0, done1,
    output shift_out, zero, busy, illegal
  );
endinterface

// File: rtl/shift_arbiter.sv
// Shares one 16-bit SLL/SRA/ROR shifter between two requesters via an
// IDLE/EXEC/DONE FSM.
// Ports: clk, rst (async, active-high), bus (shift_arbiter_if.slave).
// SHIFT_ARB_RR_EN defined: round-robin on ties; otherwise port 0 wins ties.
module shift_arbiter (
  input  logic            clk,
  input  logic            rst,
  shift_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        win_q, win_d;
  logic [15:0] opnd_q, opnd_d;
  logic [3:0]  amt_q, amt_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic        ill_q, ill_d;
  logic        pick;
  logic [15:0] sh_res;

  function automatic logic [15:0] shift_f(
    input logic [15:0] a,
    input logic [3:0]  s,
    input logic [1:0]  m
  );
    logic [15:0] r;
    unique case (m)
      2'b00:   r = a << s;
      2'b01:   r = $signed(a) >>> s;
      // a << 16 evaluates to 0, so s == 0 yields a unchanged
      2'b10:   r = (a >> s) | (a << (5'd16 - {1'b0, s}));
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  assign sh_res = shift_f(opnd_q, amt_q, mode_q);

`ifdef SHIFT_ARB_RR_EN
  logic last_q, last_d;

  // tie: the port not granted last wins
  assign pick = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && (bus.req0 | bus.req1))
      last_d = pick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  assign pick = ~bus.req0;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    opnd_d  = opnd_q;
    amt_d   = amt_q;
    mode_d  = mode_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          win_d   = pick;
          opnd_d  = pick ? bus.in1   : bus.in0;
          amt_d   = pick ? bus.val1  : bus.val0;
          mode_d  = pick ? bus.mode1 : bus.mode0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = sh_res;
        zero_d  = (sh_res == 16'h0000);
        ill_d   = (mode_q == 2'b11);
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      opnd_q  <= 16'h0000;
      amt_q   <= 4'h0;
      mode_q  <= 2'b00;
      res_q   <= 16'h0000;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      opnd_q  <= opnd_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.gnt0      = (state_q == S_EXEC) & ~win_q;
  assign bus.gnt1      = (state_q == S_EXEC) &  win_q;
  assign bus.done0     = (state_q == S_DONE) & ~win_q;
  assign bus.done1     = (state_q == S_DONE) &  win_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.shift_out = res_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed, table-driven bench for shift_arbiter.
// Covers single ops, tie arbitration, operand capture and mid-op reset.
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  shift_arbiter_if bus ();

  shift_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    logic [15:0] din;
    logic [3:0]  val;
    logic [1:0]  mode;
    logic [15:0] exp_out;
    logic        exp_zero;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.req1 = 0;
    bus.in0 = 0; bus.in1 = 0;
    bus.val0 = 0; bus.val1 = 0;
    bus.mode0 = 0; bus.mode1 = 0;
  endtask

  task automatic drive(input bit p, input logic [15:0] d,
                       input logic [3:0] v, input logic [1:0] m);
    if (p) begin
      bus.req1 = 1; bus.in1 = d; bus.val1 = v; bus.mode1 = m;
    end else begin
      bus.req0 = 1; bus.in0 = d; bus.val0 = v; bus.mode0 = m;
    end
  endtask

  // full op: request at a negedge, checks at following negedges
  task automatic run_op(input vec_t t, input int idx);
    string s;
    logic [1:0] g;
    s = $sformatf("v%0d", idx);
    @(negedge clk);
    drive(t.port, t.din, t.val, t.mode);
    @(negedge clk);
    g = t.port ? 2'b10 : 2'b01;
    chk({s, "_gnt"}, {bus.gnt1, bus.gnt0}, g);
    chk({s, "_done_early"}, {bus.done1, bus.done0}, 2'b00);
    // scramble live operands: result must use captured values
    idle_inputs();
    bus.in0 = ~t.din; bus.in1 = ~t.din;
    bus.val0 = t.val + 4'd3; bus.val1 = t.val + 4'd3;
    @(negedge clk);
    chk({s, "_done"}, {bus.done1, bus.done0}, g);
    chk({s, "_gnt_off"}, {bus.gnt1, bus.gnt0}, 2'b00);
    chk({s, "_out"}, bus.shift_out, t.exp_out);
    chk({s, "_zero"}, bus.zero, t.exp_zero);
    chk({s, "_ill"}, bus.illegal, t.exp_ill);
    @(negedge clk);
    chk({s, "_busy_end"}, bus.busy, 1'b0);
    chk({s, "_hold"}, bus.shift_out, t.exp_out);
    idle_inputs();
  endtask

  logic [1:0] exp_g [4];

  initial begin
    vecs[0]  = '{0, 16'h0001, 4'd4,  2'b00, 16'h0010, 0, 0};
    vecs[1]  = '{1, 16'h8000, 4'd15, 2'b01, 16'hFFFF, 0, 0};
    vecs[2]  = '{1, 16'h0001, 4'd1,  2'b10, 16'h8000, 0, 0};
    vecs[3]  = '{1, 16'h8000, 4'd1,  2'b00, 16'h0000, 1, 0};
    vecs[4]  = '{0, 16'hFFFF, 4'd3,  2'b11, 16'h0000, 1, 1};
    vecs[5]  = '{0, 16'h1234, 4'd0,  2'b10, 16'h1234, 0, 0};
    vecs[6]  = '{1, 16'h8421, 4'd0,  2'b01, 16'h8421, 0, 0};
    vecs[7]  = '{0, 16'h00F0, 4'd4,  2'b01, 16'h000F, 0, 0};
    vecs[8]  = '{1, 16'h8001, 4'd4,  2'b10, 16'h1800, 0, 0};
    vecs[9]  = '{0, 16'h1234, 4'd8,  2'b00, 16'h3400, 0, 0};
    vecs[10] = '{1, 16'hF000, 4'd4,  2'b01, 16'hFF00, 0, 0};
    vecs[11] = '{0, 16'h0000, 4'd5,  2'b10, 16'h0000, 1, 0};

    idle_inputs();
    rst = 1;
    #12;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
    chk("rst_done", {bus.done1, bus.done0}, 2'b00);
    chk("rst_out", bus.shift_out, 16'h0000);
    chk("rst_zero", bus.zero, 1'b0);
    chk("rst_ill", bus.illegal, 1'b0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 12; i++) run_op(vecs[i], i);

    // tie: both requests held, pointer fresh from reset
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
`ifdef SHIFT_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    drive(0, 16'h0001, 4'd1, 2'b00);
    drive(1, 16'h0001, 4'd1, 2'b10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("tie%0d_gnt", k), {bus.gnt1, bus.gnt0}, exp_g[k]);
      @(negedge clk);
      chk($sformatf("tie%0d_done", k), {bus.done1, bus.done0}, exp_g[k]);
      chk($sformatf("tie%0d_out", k), bus.shift_out,
          exp_g[k][1] ? 16'h8000 : 16'h0002);
      @(negedge clk);
      chk($sformatf("tie%0d_idle", k), bus.busy, 1'b0);
    end
    idle_inputs();

    // operands changed on gnt cycle and during EXEC
    @(negedge clk);
    drive(0, 16'h0003, 4'd2, 2'b00);
    @(negedge clk);
    chk("cap_gnt", bus.gnt0, 1'b1);
    bus.in0 = 16'hFFFF; bus.val0 = 4'd7; bus.mode0 = 2'b11;
    #3;
    bus.in0 = 16'hAAAA;
    @(negedge clk);
    chk("cap_out", bus.shift_out, 16'h000C);
    chk("cap_ill", bus.illegal, 1'b0);
    idle_inputs();
    @(negedge clk);

    // reset during EXEC drops the op
    @(negedge clk);
    drive(1, 16'h0F0F, 4'd4, 2'b00);
    @(negedge clk);
    chk("rx_gnt", bus.gnt1, 1'b1);
    idle_inputs();
    rst = 1;
    #1;
    chk("rx_gnt_drop", {bus.gnt1, bus.gnt0}, 2'b00);
    chk("rx_busy_drop", bus.busy, 1'b0);
    chk("rx_out_clr", bus.shift_out, 16'h0000);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rx_nodone%0d", k), {bus.done1, bus.done0}, 2'b00);
    end
    run_op('{1, 16'h0F0F, 4'd4, 2'b00, 16'hF0F0, 0, 0}, 99);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
